ysyx_25040129_rd_arbiter: RTL
=============================

Name: ysyx_25040129_rd_arbiter

Overview:
Two-master, one-slave read-channel arbiter that shares the single memory read port between the instruction fetch unit (master 0) and the load/store unit (master 1). It sits between both masters' AR/R channels and the memory slave. It serialises whole read transactions (AR handshake followed by R handshake) and uses round-robin selection on contention. Only one transaction is outstanding at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
ifu_araddr  input  ADDR_W  fetch read address
ifu_arvalid  input  1  fetch address valid
ifu_arready  output  1  fetch address accepted
ifu_rdata  output  DATA_W  fetch read data
ifu_rresp  output  2  fetch read response
ifu_rvalid  output  1  fetch data valid
ifu_rready  input  1  fetch ready for data
lsu_araddr  input  ADDR_W  load read address
lsu_arvalid  input  1  load address valid
lsu_arready  output  1  load address accepted
lsu_rdata  output  DATA_W  load read data
lsu_rresp  output  2  load read response
lsu_rvalid  output  1  load data valid
lsu_rready  input  1  load ready for data
mem_araddr  output  ADDR_W  slave read address
mem_arvalid  output  1  slave address valid
mem_arready  input  1  slave address accepted
mem_rdata  input  DATA_W  slave read data
mem_rresp  input  2  slave response (00 OKAY)
mem_rvalid  input  1  slave data valid
mem_rready  output  1  slave data ready

Behaviour:
- Registers:
  - state: IDLE=0, ADDR=1, DATA=2
  - owner: 0=IFU, 1=LSU
  - last: owner of the last completed transaction
- Reset values: state=IDLE, owner=0, last=1 (so IFU wins the first tie).
- Outputs with no active owner:
  - All valid/ready outputs are 0.
  - mem_araddr is 0.
- IDLE:
  - No arvalid asserted: remain in IDLE.
  - Exactly one arvalid asserted: owner <= that master; state <= ADDR.
  - Both asserted: owner <= !last; state <= ADDR.
  - No handshake happens in IDLE, so there is a 1-cycle arbitration bubble.
- ADDR:
  - mem_araddr and mem_arvalid are driven from the owner's AR channel.
  - Owner's arready = mem_arready; the non-owner's arready = 0.
  - On mem_arvalid & mem_arready: state <= DATA.
  - The owner must hold arvalid/araddr until the handshake completes. Dropping arvalid stalls the arbiter in ADDR.
- DATA:
  - mem_rready = owner's rready.
  - Owner's rvalid = mem_rvalid; the non-owner's rvalid = 0.
  - On mem_rvalid & mem_rready: state <= IDLE; last <= owner.
- Data and response routing:
  - rdata/rresp are combinationally broadcast to both masters from mem_rdata/mem_rresp.
  - Only the owner's rvalid is qualified.
- Non-owner requests:
  - A request from the non-owner that arrives during ADDR/DATA waits, with arready held at 0.
  - It is granted in the next IDLE cycle.
- Error responses: a non-OKAY rresp is passed through unchanged. There is no retry and no state change beyond normal completion.
- Minimum latency from arvalid to mem_arvalid is 1 cycle. Minimum end-to-end with a zero-wait slave is 3 cycles (IDLE, ADDR, DATA).
- Simultaneous events:
  - An R handshake in the same cycle as a new arvalid returns the arbiter to IDLE first.
  - A new grant never starts in the completing cycle.
- Reset mid-operation:
  - On the next edge: state=IDLE, owner=0, last=1.
  - All outputs drop to 0 immediately.
  - Any in-flight slave response is abandoned; the slave is reset by the same rst.
- Fairness: round-robin alternation guarantees no starvation when both masters request continuously.

Test Plan:
- Reset, then IFU only with araddr=0x80000000 and a slave returning 0x00000413/OKAY after 2 cycles -> mem_araddr=0x80000000; ifu_rdata=0x00000413; ifu_rvalid=1 for one handshake; lsu_rvalid stays 0.
- Both arvalid asserted in the same cycle immediately after reset -> IFU is granted first. After completion, LSU (araddr=0x80001000) is granted. Masters are granted in IFU, LSU order.
- Both masters hold arvalid for 4 transactions -> grants alternate IFU, LSU, IFU, LSU. mem_araddr matches each owner's address.
- LSU asserts arvalid while the IFU transaction is in DATA and the slave stalls rvalid for 5 cycles -> lsu_arready=0 throughout. LSU is granted the cycle after the IFU R handshake.
- Slave returns rresp=2'b10 for an LSU read -> lsu_rresp=2'b10 and lsu_rvalid=1. The arbiter returns to IDLE and the next request is granted normally.
- rst asserted while in DATA -> next cycle state=IDLE and all valid/ready outputs are 0. A fresh IFU request then completes correctly.

Source files
------------

// File: rtl/ysyx_25040129_rd_arbiter.sv
// Two-master read-channel arbiter: serialises whole IFU/LSU read transactions
// (AR then R) onto a single memory read port, round-robin on contention.
module ysyx_25040129_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,

  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,

  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready
);

  // state | meaning
  // IDLE  | no owner; pick among pending arvalid (one-cycle arbitration bubble)
  // ADDR  | owner's AR channel routed to the slave, waiting for AR handshake
  // DATA  | owner's R channel routed from the slave, waiting for R handshake
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic              own_arvalid;
  logic              own_rready;
  logic [ADDR_W-1:0] own_araddr;

  // owner: 0 = IFU, 1 = LSU
  assign own_arvalid = owner_q ? lsu_arvalid : ifu_arvalid;
  assign own_araddr  = owner_q ? lsu_araddr  : ifu_araddr;
  assign own_rready  = owner_q ? lsu_rready  : ifu_rready;

  // Data and response are broadcast; only rvalid is qualified by ownership.
  assign ifu_rdata = mem_rdata;
  assign ifu_rresp = mem_rresp;
  assign lsu_rdata = mem_rdata;
  assign lsu_rresp = mem_rresp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;

    // Handshake outputs are forced low while rst is held, not just after the edge.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (ifu_arvalid || lsu_arvalid) begin
            owner_d = (ifu_arvalid && lsu_arvalid) ? ~last_q : lsu_arvalid;
            state_d = ADDR;
          end
        end
        ADDR: begin
          mem_araddr  = own_araddr;
          mem_arvalid = own_arvalid;
          ifu_arready = ~owner_q & mem_arready;
          lsu_arready =  owner_q & mem_arready;
          if (own_arvalid && mem_arready) begin
            state_d = DATA;
          end
        end
        DATA: begin
          mem_rready = own_rready;
          ifu_rvalid = ~owner_q & mem_rvalid;
          lsu_rvalid =  owner_q & mem_rvalid;
          if (mem_rvalid && own_rready) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
